// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D-cache memory port arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  localparam logic MST_I = 1'b0;
  localparam logic MST_D = 1'b1;

  function automatic arb_state_e gnt_state(input logic mst);
    return (mst == MST_D) ? GNT_D : GNT_I;
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both cache-side memory interfaces plus the shared memory port.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              i_mem_read;
  logic              i_mem_write;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [DATA_W-1:0] i_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              i_mem_ready;

  logic              d_mem_read;
  logic              d_mem_write;
  logic [ADDR_W-1:0] d_mem_addr;
  logic [DATA_W-1:0] d_mem_wdata;
  logic [DATA_W-1:0] d_mem_rdata;
  logic              d_mem_ready;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  // Arbiter side
  modport slave (
    input  i_mem_read, i_mem_write, i_mem_addr, i_mem_wdata,
    output i_mem_rdata, i_mem_ready,
    input  d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
    output d_mem_rdata, d_mem_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  // Caches and memory model side
  modport master (
    output i_mem_read, i_mem_write, i_mem_addr, i_mem_wdata,
    input  i_mem_rdata, i_mem_ready,
    output d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
    input  d_mem_rdata, d_mem_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master block memory arbiter, grant locked per transaction until mem_ready.
// Tie policy is round-robin; define MEM_ARB_DPRIO_EN for fixed D-cache priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic          clk,
  input  logic          proc_reset,
  mem_arbiter_if.slave  bus
);

  arb_state_e        state_q, state_d;
  logic              req_i, req_d, pick;
  logic              rd_o, wr_o, i_rdy, d_rdy;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] wdata_o;

  assign req_i = bus.i_mem_read | bus.i_mem_write;
  assign req_d = bus.d_mem_read | bus.d_mem_write;

`ifdef MEM_ARB_DPRIO_EN
  always_comb begin
    pick = MST_I;
    if (req_d) pick = MST_D;
  end
`else
  logic last_gnt_q, last_gnt_d;

  always_comb begin
    pick = MST_I;
    if (req_i && req_d) pick = ~last_gnt_q;
    else if (req_d)     pick = MST_D;
  end

  assign last_gnt_d = (state_q == IDLE && (req_i || req_d)) ? pick : last_gnt_q;

  // Reset to D so the first tie goes to the I-cache
  always_ff @(posedge clk) begin
    if (proc_reset) last_gnt_q <= MST_D;
    else            last_gnt_q <= last_gnt_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (proc_reset) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rd_o    = 1'b0;
    wr_o    = 1'b0;
    addr_o  = '0;
    wdata_o = '0;
    i_rdy   = 1'b0;
    d_rdy   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i || req_d) state_d = gnt_state(pick);
      end
      GNT_I: begin
        rd_o    = bus.i_mem_read;
        wr_o    = bus.i_mem_write;
        addr_o  = bus.i_mem_addr;
        wdata_o = bus.i_mem_wdata;
        i_rdy   = bus.mem_ready;
        // Dropped request without ready only happens after a cache-side reset
        if (bus.mem_ready || !req_i) state_d = IDLE;
      end
      GNT_D: begin
        rd_o    = bus.d_mem_read;
        wr_o    = bus.d_mem_write;
        addr_o  = bus.d_mem_addr;
        wdata_o = bus.d_mem_wdata;
        d_rdy   = bus.mem_ready;
        if (bus.mem_ready || !req_d) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_read    = rd_o;
  assign bus.mem_write   = wr_o;
  assign bus.mem_addr    = addr_o;
  assign bus.mem_wdata   = wdata_o;
  assign bus.i_mem_ready = i_rdy;
  assign bus.d_mem_ready = d_rdy;
  assign bus.i_mem_rdata = bus.mem_rdata;
  assign bus.d_mem_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; tie-break expectations follow MEM_ARB_DPRIO_EN.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

`ifdef MEM_ARB_DPRIO_EN
  localparam bit DPRIO = 1'b1;
`else
  localparam bit DPRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic proc_reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  mem_arbiter_if #(.ADDR_W(28), .DATA_W(128)) bus ();

  mem_arbiter #(.ADDR_W(28), .DATA_W(128)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr_inputs();
    bus.i_mem_read  = 1'b0; bus.i_mem_write = 1'b0;
    bus.i_mem_addr  = '0;   bus.i_mem_wdata = '0;
    bus.d_mem_read  = 1'b0; bus.d_mem_write = 1'b0;
    bus.d_mem_addr  = '0;   bus.d_mem_wdata = '0;
    bus.mem_rdata   = '0;   bus.mem_ready   = 1'b0;
  endtask

  task automatic do_reset();
    proc_reset = 1'b1;
    clr_inputs();
    step();
    step();
    proc_reset = 1'b0;
  endtask

  // Both caches request a read together; check the winner, then the loser.
  task automatic both_round(input string tag, input bit first_d);
    logic [27:0] fa, sa;
    fa = first_d ? 28'h30 : 28'h20;
    sa = first_d ? 28'h20 : 28'h30;
    bus.i_mem_read = 1'b1; bus.i_mem_addr = 28'h20;
    bus.d_mem_read = 1'b1; bus.d_mem_addr = 28'h30;
    settle();
    chk({tag, "_lat"}, 128'(bus.mem_read), 128'h0);
    step();
    chk({tag, "_first_addr"}, 128'(bus.mem_addr), 128'(fa));
    bus.mem_ready = 1'b1;
    if (first_d) bus.d_mem_read = 1'b0; else bus.i_mem_read = 1'b0;
    settle();
    chk({tag, "_first_rdy"}, 128'({bus.i_mem_ready, bus.d_mem_ready}),
        first_d ? 128'h1 : 128'h2);
    step();
    bus.mem_ready = 1'b0;
    settle();
    chk({tag, "_gap_idle"}, 128'(bus.mem_read), 128'h0);
    step();
    chk({tag, "_second_addr"}, 128'({bus.mem_read, bus.mem_addr}), 128'({1'b1, sa}));
    bus.mem_ready = 1'b1;
    bus.i_mem_read = 1'b0; bus.d_mem_read = 1'b0;
    settle();
    chk({tag, "_second_rdy"}, 128'({bus.i_mem_ready, bus.d_mem_ready}),
        first_d ? 128'h2 : 128'h1);
    step();
    bus.mem_ready = 1'b0;
    settle();
    chk({tag, "_end_idle"}, 128'(bus.mem_read), 128'h0);
  endtask

  initial begin
    logic [127:0] pat;
    pat = {16{8'hA5}};

    // Reset values
    do_reset();
    chk("rst_outs", 128'({bus.mem_read, bus.mem_write, bus.i_mem_ready, bus.d_mem_ready}), 128'h0);
    chk("rst_addr", 128'(bus.mem_addr), 128'h0);
    chk("rst_wdata", bus.mem_wdata, 128'h0);

    // I read alone, 5-cycle memory
    bus.i_mem_read = 1'b1; bus.i_mem_addr = 28'h0000010;
    settle();
    chk("i_lat", 128'(bus.mem_read), 128'h0);
    step();
    chk("i_gnt", 128'({bus.mem_read, bus.mem_addr}), 128'({1'b1, 28'h0000010}));
    for (int k = 0; k < 4; k++) step();
    chk("i_hold", 128'(bus.mem_read), 128'h1);
    bus.mem_ready = 1'b1; bus.mem_rdata = pat; bus.i_mem_read = 1'b0;
    settle();
    chk("i_rdy", 128'({bus.i_mem_ready, bus.d_mem_ready}), 128'h2);
    chk("i_rdata", bus.i_mem_rdata, pat);
    chk("d_rdata_bcast", bus.d_mem_rdata, pat);
    step();
    bus.mem_ready = 1'b0;
    settle();
    chk("i_back_idle", 128'({bus.mem_read, bus.i_mem_ready}), 128'h0);
    bus.mem_ready = 1'b1;
    settle();
    chk("idle_rdy_ignored", 128'({bus.i_mem_ready, bus.d_mem_ready}), 128'h0);
    step();
    bus.mem_ready = 1'b0;

    // Last grant was I, so a tie goes to D (and always D under fixed priority)
    both_round("rr_after_i", 1'b1);

    // Fresh reset: I wins first tie; D must not win twice in a row
    do_reset();
    both_round("tie0", DPRIO);
    both_round("tie1", DPRIO);

    // D write-back with I arriving mid-transaction, then D refill
    do_reset();
    bus.d_mem_write = 1'b1; bus.d_mem_addr = 28'h0000123; bus.d_mem_wdata = 128'h1;
    step();
    chk("wb_wr", 128'({bus.mem_read, bus.mem_write}), 128'h1);
    chk("wb_addr", 128'(bus.mem_addr), 128'h123);
    chk("wb_wdata", bus.mem_wdata, 128'h1);
    bus.i_mem_read = 1'b1; bus.i_mem_addr = 28'h0000040;
    step();
    chk("wb_hold1", 128'(bus.mem_addr), 128'h123);
    step();
    chk("wb_hold2", 128'({bus.mem_read, bus.mem_write, bus.mem_addr}), 128'({2'b01, 28'h123}));
    bus.mem_ready = 1'b1; bus.d_mem_write = 1'b0;
    settle();
    chk("wb_rdy", 128'({bus.i_mem_ready, bus.d_mem_ready}), 128'h1);
    step();
    bus.mem_ready = 1'b0; bus.d_mem_read = 1'b1;
    settle();
    chk("wb_gap_idle", 128'({bus.mem_read, bus.mem_write}), 128'h0);
    step();
    chk("after_wb_addr", 128'({bus.mem_read, bus.mem_addr}),
        DPRIO ? 128'({1'b1, 28'h123}) : 128'({1'b1, 28'h40}));

    // Reset while D holds the grant
    do_reset();
    bus.d_mem_read = 1'b1; bus.d_mem_addr = 28'h0000055;
    step();
    chk("rstmid_gnt", 128'({bus.mem_read, bus.mem_addr}), 128'({1'b1, 28'h55}));
    proc_reset = 1'b1;
    step();
    chk("rstmid_outs", 128'({bus.mem_read, bus.mem_write}), 128'h0);
    proc_reset = 1'b0; bus.d_mem_read = 1'b0; bus.mem_ready = 1'b1;
    settle();
    chk("rstmid_late_rdy", 128'({bus.i_mem_ready, bus.d_mem_ready}), 128'h0);
    step();
    bus.mem_ready = 1'b0;

    // Granted I aborts; pending D follows
    do_reset();
    bus.i_mem_read = 1'b1; bus.i_mem_addr = 28'h0000060;
    step();
    chk("abort_gnt", 128'({bus.mem_read, bus.mem_addr}), 128'({1'b1, 28'h60}));
    bus.d_mem_read = 1'b1; bus.d_mem_addr = 28'h0000070;
    step();
    chk("abort_lock", 128'(bus.mem_addr), 128'h60);
    bus.i_mem_read = 1'b0;
    settle();
    chk("abort_no_rdy", 128'({bus.i_mem_ready, bus.d_mem_ready}), 128'h0);
    step();
    chk("abort_idle", 128'(bus.mem_read), 128'h0);
    step();
    chk("abort_d_gnt", 128'({bus.mem_read, bus.mem_addr}), 128'({1'b1, 28'h70}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
